// File: rtl/sfp_pkg.sv
// Shared encodings and defaults for the TX frame path.
package sfp_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ACK, ST_XFER, ST_FLUSH, ST_GAP} state_t;

  localparam int DEF_IFG_CYCLES = 12;
  localparam int DEF_MAX_LEN    = 2047;
  localparam int LEN_W          = 12;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       ovs;
  } beat_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit after index 'last', wrapping.
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
)(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        last,
  output logic [PW-1:0]        sel,
  output logic                 found
);
  logic [PW-1:0] idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = last;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (idx == PW'(NUM_PORTS-1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
endmodule

// File: rtl/tx_frame_arb.sv
// N-port frame arbiter: round-robin grant, 1-byte hold so eof is exact, forced IFG.
module tx_frame_arb
  import sfp_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int IFG_CYCLES = DEF_IFG_CYCLES,
  parameter int MAX_LEN    = DEF_MAX_LEN
)(
  input  logic                         tx_clk,
  input  logic                         tx_rst_n,
  input  logic [NUM_PORTS-1:0]         port_en,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [8*NUM_PORTS-1:0]       req_data,
  output logic [NUM_PORTS-1:0]         req_ack,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  output logic                         out_sof,
  output logic                         out_eof,
  output logic [$clog2(NUM_PORTS)-1:0] out_port,
  output logic                         out_oversize,
  output logic                         busy
);
  localparam int PW = $clog2(NUM_PORTS);

  state_t                      state, state_nx;
  logic [PW-1:0]               last_grant, pick;
  logic                        found, cur_vld;
  logic [NUM_PORTS-1:0][7:0]   req_bytes;
  logic [7:0]                  hold;
  logic                        hold_vld, first;
  logic [LEN_W-1:0]            len;
  logic [7:0]                  gap_cnt;
  beat_t                       beat;

  assign req_bytes = req_data;
  // last_grant doubles as the active port once a frame is granted
  assign cur_vld   = req_valid[last_grant];

  rr_pick #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_pick (
    .req   (req_valid & port_en),
    .last  (last_grant),
    .sel   (pick),
    .found (found)
  );

  always_ff @(posedge tx_clk or negedge tx_rst_n)
    if (!tx_rst_n) state <= ST_IDLE;
    else           state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (found) state_nx = ST_ACK;
      ST_ACK:   state_nx = ST_XFER;
      ST_XFER:  if (!cur_vld) state_nx = hold_vld ? ST_FLUSH : ST_GAP;
      ST_FLUSH: state_nx = ST_GAP;
      ST_GAP:   if (gap_cnt == 8'(IFG_CYCLES-1)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    if (state == ST_ACK) req_ack[last_grant] = 1'b1;
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n)
    if (!tx_rst_n) begin
      last_grant <= PW'(NUM_PORTS-1);
      out_port   <= '0;
      gap_cnt    <= '0;
    end else begin
      if (state == ST_IDLE && found) begin
        last_grant <= pick;
        out_port   <= pick;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end

  // A byte is released only once the following cycle tells us whether it is the last
  always_ff @(posedge tx_clk or negedge tx_rst_n)
    if (!tx_rst_n) begin
      hold      <= '0;
      hold_vld  <= 1'b0;
      first     <= 1'b0;
      len       <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
    end else begin
      beat      <= '0;
      out_valid <= 1'b0;
      case (state)
        ST_ACK: begin
          hold_vld <= 1'b0;
          first    <= 1'b1;
          len      <= '0;
        end
        ST_XFER:
          if (cur_vld) begin
            hold     <= req_bytes[last_grant];
            hold_vld <= 1'b1;
            if (len != '1) len <= len + 1'b1;
            if (hold_vld) begin
              out_valid <= 1'b1;
              beat      <= '{data: hold, sof: first, eof: 1'b0, ovs: 1'b0};
              first     <= 1'b0;
            end
          end else if (hold_vld) begin
            out_valid <= 1'b1;
            beat      <= '{data: hold, sof: first, eof: 1'b1, ovs: (int'(len) > MAX_LEN)};
            hold_vld  <= 1'b0;
          end
        default: ;
      endcase
    end

  assign out_data     = beat.data;
  assign out_sof      = beat.sof;
  assign out_eof      = beat.eof;
  assign out_oversize = beat.ovs;
endmodule
